// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receive-only UART for 8N1 frames, LSB first. The receiving counterpart of
//   uart_tx; it shares the same clock_frequency / baud_rate parameters.
//
//   Optional feature macro: UART_RX_FRAME_ERR_EN
//     defined   : a low stop bit pulses frame_err, drops the byte and parks the
//                 FSM in BREAK until the line returns high.
//     undefined : the stop bit is not checked, every frame updates data, and
//                 frame_err is constant 0.
//
//   Ports
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     rx        : serial line, idle high, asynchronous to clk
//     data      : last correctly received byte, held until the next valid
//     valid     : one-cycle strobe when data updates
//     busy      : high whenever the receiver is not idle
//     frame_err : one-cycle strobe on a bad stop bit (macro build only)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int clock_frequency = 12000000,
  parameter int baud_rate       = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int CPP  = clock_frequency / baud_rate;
  localparam int HALF = CPP / 2;
  localparam logic [15:0] CPP_M1  = 16'(CPP - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic        r_rx_meta;
  logic        r_rx_s;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [2:0]  w_bit_cnt_next;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_data_next;
  logic        w_valid_next;
  logic        w_frame_err_next;
  logic        w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 16'd0);

  // Two-flop synchroniser; reset to the idle level so a reset never looks
  // like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_frame_err_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          // First wait only half a bit so every later sample lands mid-bit.
          w_cnt_next   = HALF_M1;
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (w_cnt_zero) begin
          if (!r_rx_s) begin
            w_cnt_next     = CPP_M1;
            w_bit_cnt_next = 3'd0;
            w_state_next   = S_DATA;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end

      S_DATA: begin
        if (w_cnt_zero) begin
          w_shift_next = {r_rx_s, r_shift[7:1]};
          w_cnt_next   = CPP_M1;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end

      S_STOP: begin
        if (w_cnt_zero) begin
`ifdef UART_RX_FRAME_ERR_EN
          if (r_rx_s) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = S_BREAK;
          end
`else
          w_data_next  = r_shift;
          w_valid_next = 1'b1;
          w_state_next = S_IDLE;
`endif
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end

      S_BREAK: begin
        // Hold off until the line is released so a long low level cannot
        // be mistaken for a fresh start bit.
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_frame_err;

endmodule
